// File: rtl/ball_motion.sv
// ball_motion: once per video frame, walks every ball one per clock. Each ball
// picks up pending brick bounces, moves by its velocity and resolves walls,
// ceiling, paddle and floor. Packed centres and the active mask feed the renderer.
module ball_motion #(
    parameter int BALL_NUM = 2,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int RADIUS   = 8,
    parameter int PADDLE_Y = 440
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_tick,
    input  logic [BALL_NUM-1:0]   serve,
    input  logic [BALL_NUM-1:0]   bounce_x,
    input  logic [BALL_NUM-1:0]   bounce_y,
    input  logic [9:0]            paddle_x,
    input  logic [7:0]            paddle_w,
    output logic [BALL_NUM*10-1:0] xs,
    output logic [BALL_NUM*10-1:0] ys,
    output logic [BALL_NUM-1:0]   active,
    output logic [5:0]            radius,
    output logic [BALL_NUM-1:0]   lost,
    output logic                  busy
);

    localparam int IDX_W = (BALL_NUM > 1) ? $clog2(BALL_NUM) : 1;
    localparam logic signed [11:0] X_MIN = 12'(RADIUS);
    localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1 - RADIUS);
    localparam logic signed [11:0] Y_MIN = 12'(RADIUS);
    localparam logic signed [11:0] Y_PAD = 12'(PADDLE_Y - RADIUS);
    localparam logic signed [11:0] Y_BOT = 12'(SCREEN_H);
    localparam logic [9:0]         X_HOME = 10'(SCREEN_W / 2);
    localparam logic [9:0]         Y_HOME = 10'(PADDLE_Y - RADIUS - 1);
    localparam logic signed [3:0]  V_SERVE_X = 4'sd2;
    localparam logic signed [3:0]  V_SERVE_Y = -4'sd2;

    typedef enum logic [1:0] {B_INACTIVE, B_PARKED, B_MOVING} ball_state_t;
    typedef enum logic {S_IDLE, S_UPD} sweep_state_t;

    sweep_state_t       sweep_reg, sweep_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;

    ball_state_t        bst_reg  [BALL_NUM];
    ball_state_t        bst_next [BALL_NUM];
    logic [9:0]         x_reg    [BALL_NUM];
    logic [9:0]         x_next   [BALL_NUM];
    logic [9:0]         y_reg    [BALL_NUM];
    logic [9:0]         y_next   [BALL_NUM];
    logic signed [3:0]  vx_reg   [BALL_NUM];
    logic signed [3:0]  vx_next  [BALL_NUM];
    logic signed [3:0]  vy_reg   [BALL_NUM];
    logic signed [3:0]  vy_next  [BALL_NUM];
    logic               px_reg   [BALL_NUM];
    logic               px_next  [BALL_NUM];
    logic               py_reg   [BALL_NUM];
    logic               py_next  [BALL_NUM];
    logic               lost_reg [BALL_NUM];
    logic               lost_next[BALL_NUM];
    logic [BALL_NUM-1:0] upd_sel;

    // Shared datapath signals for the ball selected by idx_reg
    logic signed [11:0] cx, cy, nx, ny, pl, pr, pkx;
    logic signed [3:0]  vxa, vya, mv_vx, mv_vy;
    logic               mv_lost;
    ball_state_t        u_st;
    logic [9:0]         u_x, u_y;
    logic signed [3:0]  u_vx, u_vy;
    logic               u_lost;

    function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
        return v[3] ? -v : v;
    endfunction

    // Sweep state and ball index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_reg <= S_IDLE;
            idx_reg   <= '0;
        end else begin
            sweep_reg <= sweep_next;
            idx_reg   <= idx_next;
        end
    end

    // Sweep next-state: start on frame_tick, visit each ball once, then idle
    always_comb begin
        sweep_next = sweep_reg;
        idx_next   = idx_reg;
        busy       = 1'b0;
        case (sweep_reg)
            S_IDLE: begin
                if (frame_tick) begin
                    sweep_next = S_UPD;
                    idx_next   = '0;
                end
            end
            S_UPD: begin
                busy = 1'b1;
                if (idx_reg == IDX_W'(BALL_NUM - 1)) begin
                    sweep_next = S_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: sweep_next = S_IDLE;
        endcase
    end

    // Update datapath: flips, move, walls, ceiling, paddle, floor (12-bit signed)
    always_comb begin
        cx    = $signed({2'b00, x_reg[idx_reg]});
        cy    = $signed({2'b00, y_reg[idx_reg]});
        vxa   = px_reg[idx_reg] ? -vx_reg[idx_reg] : vx_reg[idx_reg];
        vya   = py_reg[idx_reg] ? -vy_reg[idx_reg] : vy_reg[idx_reg];
        mv_vx = vxa;
        mv_vy = vya;
        nx    = cx + {{8{vxa[3]}}, vxa};
        ny    = cy + {{8{vya[3]}}, vya};
        if (nx < X_MIN) begin
            nx    = X_MIN;
            mv_vx = abs4(mv_vx);
        end
        if (nx > X_MAX) begin
            nx    = X_MAX;
            mv_vx = -abs4(mv_vx);
        end
        if (ny < Y_MIN) begin
            ny    = Y_MIN;
            mv_vy = abs4(mv_vy);
        end
        pl = $signed({2'b00, paddle_x});
        pr = pl + $signed({4'b0000, paddle_w});
        // Paddle only catches a descending ball crossing its top surface
        if (mv_vy > 0 && cy <= Y_PAD && ny >= Y_PAD && nx >= pl && nx <= pr) begin
            ny    = Y_PAD;
            mv_vy = -mv_vy;
        end
        mv_lost = (ny >= Y_BOT);

        // A parked ball rides on the paddle centre, kept inside the walls
        pkx = $signed({2'b00, paddle_x}) + $signed({5'b00000, paddle_w[7:1]});
        if (pkx < X_MIN) begin
            pkx = X_MIN;
        end else if (pkx > X_MAX) begin
            pkx = X_MAX;
        end

        u_st   = bst_reg[idx_reg];
        u_x    = x_reg[idx_reg];
        u_y    = y_reg[idx_reg];
        u_vx   = vx_reg[idx_reg];
        u_vy   = vy_reg[idx_reg];
        u_lost = 1'b0;
        case (bst_reg[idx_reg])
            B_PARKED: begin
                u_x = pkx[9:0];
                u_y = Y_HOME;
            end
            B_MOVING: begin
                u_vx = mv_vx;
                u_vy = mv_vy;
                if (mv_lost) begin
                    // Lost ball keeps its last drawn position
                    u_st   = B_INACTIVE;
                    u_lost = 1'b1;
                end else begin
                    u_x = nx[9:0];
                    u_y = ny[9:0];
                end
            end
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BALL_NUM; gi = gi + 1) begin : g_ball
            assign upd_sel[gi]      = (sweep_reg == S_UPD) && (idx_reg == IDX_W'(gi));
            assign xs[gi*10 +: 10]  = x_reg[gi];
            assign ys[gi*10 +: 10]  = y_reg[gi];
            assign active[gi]       = (bst_reg[gi] != B_INACTIVE);
            assign lost[gi]         = lost_reg[gi];
        end
    endgenerate

    assign radius = 6'(RADIUS);

    // Per-ball next state: sweep update first, then serve, then sticky bounce flags
    always_comb begin
        for (int i = 0; i < BALL_NUM; i++) begin
            bst_next[i]  = bst_reg[i];
            x_next[i]    = x_reg[i];
            y_next[i]    = y_reg[i];
            vx_next[i]   = vx_reg[i];
            vy_next[i]   = vy_reg[i];
            lost_next[i] = 1'b0;
            if (upd_sel[i]) begin
                bst_next[i]  = u_st;
                x_next[i]    = u_x;
                y_next[i]    = u_y;
                vx_next[i]   = u_vx;
                vy_next[i]   = u_vy;
                lost_next[i] = u_lost;
            end
            if (serve[i]) begin
                case (bst_next[i])
                    B_INACTIVE: bst_next[i] = B_PARKED;
                    B_PARKED: begin
                        bst_next[i] = B_MOVING;
                        vx_next[i]  = V_SERVE_X;
                        vy_next[i]  = V_SERVE_Y;
                    end
                    default: ;
                endcase
            end
            // A pulse landing on the clearing update survives to the next frame
            px_next[i] = (px_reg[i] & ~upd_sel[i]) | bounce_x[i];
            py_next[i] = (py_reg[i] & ~upd_sel[i]) | bounce_y[i];
        end
    end

    // Per-ball state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BALL_NUM; i++) begin
                bst_reg[i]  <= B_INACTIVE;
                x_reg[i]    <= X_HOME;
                y_reg[i]    <= Y_HOME;
                vx_reg[i]   <= V_SERVE_X;
                vy_reg[i]   <= V_SERVE_Y;
                px_reg[i]   <= 1'b0;
                py_reg[i]   <= 1'b0;
                lost_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < BALL_NUM; i++) begin
                bst_reg[i]  <= bst_next[i];
                x_reg[i]    <= x_next[i];
                y_reg[i]    <= y_next[i];
                vx_reg[i]   <= vx_next[i];
                vy_reg[i]   <= vy_next[i];
                px_reg[i]   <= px_next[i];
                py_reg[i]   <= py_next[i];
                lost_reg[i] <= lost_next[i];
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed scenarios for ball_motion with hand-computed
// positions; outputs are sampled on the falling clock edge.
module tb_ball_motion;

    localparam int BN = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame_tick;
    logic [BN-1:0]   serve, bounce_x, bounce_y;
    logic [9:0]      paddle_x;
    logic [7:0]      paddle_w;
    logic [BN*10-1:0] xs, ys;
    logic [BN-1:0]   active, lost;
    logic [5:0]      radius;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int busy_len;
    int lost0_hits;
    int tick_no = 0;

    ball_motion dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
        .bounce_x(bounce_x), .bounce_y(bounce_y), .paddle_x(paddle_x),
        .paddle_w(paddle_w), .xs(xs), .ys(ys), .active(active),
        .radius(radius), .lost(lost), .busy(busy)
    );

    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset");
    endtask

    task automatic serve_pulse(input logic [BN-1:0] m);
        @(negedge clk);
        serve = m;
        @(negedge clk);
        serve = '0;
        $display("serve %b: active=%b xs0=%0d ys0=%0d", m, active, xs[9:0], ys[9:0]);
    endtask

    task automatic bounce_pulse(input logic [BN-1:0] bx, input logic [BN-1:0] by);
        @(negedge clk);
        bounce_x = bx;
        bounce_y = by;
        @(negedge clk);
        bounce_x = '0;
        bounce_y = '0;
        $display("bounce x=%b y=%b", bx, by);
    endtask

    // One frame sweep; bx is driven during the last ball's update cycle
    task automatic tick(input logic [BN-1:0] bx);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        busy_len   = 0;
        lost0_hits = 0;
        while (busy && busy_len < 8) begin
            busy_len++;
            if (busy_len == BN) bounce_x = bx;
            @(negedge clk);
            bounce_x = '0;
            if (lost[0]) lost0_hits++;
        end
        @(negedge clk);
        if (lost[0]) lost0_hits++;
        tick_no++;
        chk("busy_len", busy_len, BN);
        $display("tick %0d: busy_len=%0d xs=%0d,%0d ys=%0d,%0d active=%b lost0=%0d",
                 tick_no, busy_len, xs[9:0], xs[19:10], ys[9:0], ys[19:10], active, lost0_hits);
    endtask

    // Ball 0 parked at 209, up-right to the corner (631,9), reflected, then down-left to (209,430)
    task automatic run_to_paddle();
        do_reset();
        paddle_x = 10'd209;
        paddle_w = 8'd0;
        serve_pulse(2'b01);
        tick(2'b00);
        chk("park_209_x", xs[9:0], 209);
        serve_pulse(2'b01);
        repeat (211) tick(2'b00);
        chk("pre_corner_x", xs[9:0], 631);
        chk("pre_corner_y", ys[9:0], 9);
        tick(2'b00);
        chk("corner_x", xs[9:0], 631);
        chk("corner_y", ys[9:0], 8);
        tick(2'b00);
        chk("post_corner_x", xs[9:0], 629);
        chk("post_corner_y", ys[9:0], 10);
        repeat (210) tick(2'b00);
        chk("descend_x", xs[9:0], 209);
        chk("descend_y", ys[9:0], 430);
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        serve      = '0;
        bounce_x   = '0;
        bounce_y   = '0;
        paddle_x   = 10'd300;
        paddle_w   = 8'd40;
        repeat (2) @(negedge clk);
        chk("rst_active", active, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lost", lost, 0);
        chk("rst_xs", xs, {10'd320, 10'd320});
        chk("rst_ys", ys, {10'd431, 10'd431});
        chk("radius", radius, 8);
        rst = 1'b0;

        // Serve twice then one frame
        serve_pulse(2'b01);
        chk("serve1_active", active, 2'b01);
        chk("serve1_x", xs[9:0], 320);
        chk("serve1_y", ys[9:0], 431);
        serve_pulse(2'b01);
        tick(2'b00);
        chk("first_move_x", xs[9:0], 322);
        chk("first_move_y", ys[9:0], 429);
        chk("ball1_idle_x", xs[19:10], 320);
        chk("first_busy_low", busy, 0);

        // Parked clamping and left wall
        do_reset();
        paddle_w = 8'd0;
        paddle_x = 10'd0;
        serve_pulse(2'b01);
        tick(2'b00);
        chk("park_clamp_lo", xs[9:0], 8);
        paddle_x = 10'd1000;
        tick(2'b00);
        chk("park_clamp_hi", xs[9:0], 631);
        chk("park_y", ys[9:0], 431);
        paddle_x = 10'd11;
        tick(2'b00);
        chk("park_11", xs[9:0], 11);
        serve_pulse(2'b01);
        bounce_pulse(2'b01, 2'b00);
        tick(2'b00);
        chk("left_pre_x", xs[9:0], 9);
        chk("left_pre_y", ys[9:0], 429);
        tick(2'b00);
        chk("left_clamp_x", xs[9:0], 8);
        chk("left_clamp_y", ys[9:0], 427);
        tick(2'b00);
        chk("left_reflect_x", xs[9:0], 10);

        // Corner then paddle hit
        run_to_paddle();
        paddle_x = 10'd200;
        paddle_w = 8'd40;
        tick(2'b00);
        chk("paddle_hit_x", xs[9:0], 207);
        chk("paddle_hit_y", ys[9:0], 432);
        tick(2'b00);
        chk("paddle_up_y", ys[9:0], 430);
        chk("paddle_up_x", xs[9:0], 205);

        // Paddle out of reach, ball falls to the floor
        run_to_paddle();
        paddle_x = 10'd0;
        paddle_w = 8'd40;
        tick(2'b00);
        chk("miss_y", ys[9:0], 432);
        tick(2'b00);
        chk("miss_down_y", ys[9:0], 434);
        chk("miss_down_x", xs[9:0], 205);
        repeat (22) tick(2'b00);
        chk("pre_floor_y", ys[9:0], 478);
        chk("pre_floor_x", xs[9:0], 161);
        chk("pre_floor_lost", lost0_hits, 0);
        tick(2'b00);
        chk("floor_lost_pulse", lost0_hits, 1);
        chk("floor_active", active, 0);
        chk("floor_keep_x", xs[9:0], 161);
        chk("floor_keep_y", ys[9:0], 478);
        serve_pulse(2'b01);
        chk("repark_active", active, 2'b01);
        paddle_x = 10'd100;
        tick(2'b00);
        chk("repark_x", xs[9:0], 120);
        chk("repark_y", ys[9:0], 431);

        // Bounce coinciding with ball 1's update is kept for the next frame
        do_reset();
        paddle_x = 10'd300;
        paddle_w = 8'd40;
        serve_pulse(2'b10);
        tick(2'b00);
        chk("b1_park_x", xs[19:10], 320);
        serve_pulse(2'b10);
        tick(2'b10);
        chk("b1_noflip_x", xs[19:10], 322);
        chk("b1_noflip_y", ys[19:10], 429);
        tick(2'b00);
        chk("b1_flip_x", xs[19:10], 320);
        chk("b1_flip_y", ys[19:10], 427);
        tick(2'b00);
        chk("b1_cleared_x", xs[19:10], 318);
        bounce_pulse(2'b00, 2'b10);
        tick(2'b00);
        chk("b1_yflip_y", ys[19:10], 427);
        chk("b1_yflip_x", xs[19:10], 316);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_xs", xs, {10'd320, 10'd320});
        chk("mid_rst_ys", ys, {10'd431, 10'd431});
        chk("mid_rst_lost", lost, 0);
        $display("async reset mid-sweep: busy=%b active=%b", busy, active);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Produces the per-ball state that the ball renderer consumes: packed centre coordinates `xs`/`ys`, `active` mask and `radius`.
- Once per video frame it walks all balls in turn. For each ball it applies pending bounce requests from the brick-collision logic, then advances the position by the ball's velocity. It resolves wall, paddle and floor interactions and reports lost balls to the game controller.

Parameters:
- BALL_NUM, 2, number of balls (packed width of `xs`/`ys` is BALL_NUM*10).
- SCREEN_W, 640, visible width in pixels.
- SCREEN_H, 480, visible height in pixels.
- RADIUS, 8, ball radius in pixels (1..63).
- PADDLE_Y, 440, y of the paddle top surface.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_tick  in  1  one-cycle pulse at the end of the visible frame; starts an update sweep
- serve  in  BALL_NUM  per-ball pulse: inactive→PARKED, PARKED→MOVING, ignored when MOVING
- bounce_x  in  BALL_NUM  per-ball pulse requesting a vx sign flip (brick hit)
- bounce_y  in  BALL_NUM  per-ball pulse requesting a vy sign flip (brick hit)
- paddle_x  in  10  paddle left edge
- paddle_w  in  8  paddle width
- xs  out  BALL_NUM*10  packed x centres, ball i at [i*10+:10]
- ys  out  BALL_NUM*10  packed y centres
- active  out  BALL_NUM  ball i is drawn
- radius  out  6  constant RADIUS
- lost  out  BALL_NUM  one-cycle pulse when ball i falls off the bottom
- busy  out  1  high while a sweep is in progress

Behaviour:
- Reset, asynchronous, and also mid-sweep:
  - all balls INACTIVE, active=0
  - xs = SCREEN_W/2 each, ys = PADDLE_Y-RADIUS-1 each
  - vx=+2, vy=-2 each; velocities are 4-bit signed
  - pending flags cleared, lost=0, busy=0, sweep FSM in IDLE
- Per-ball state: INACTIVE, PARKED, MOVING.
- serve[i] is acted on in the cycle it is sampled:
  - INACTIVE→PARKED: active[i]=1.
  - PARKED→MOVING: vx=+2, vy=-2.
  - A serve arriving in the same cycle ball i is being updated takes effect after that update.
- Pending flags:
  - A bounce_x/bounce_y pulse sets sticky flag px[i]/py[i].
  - The flags are cleared when ball i is updated.
  - If a pulse coincides with the clearing update, the flag stays set for the next frame.
- Sweep FSM, states IDLE and UPD:
  - IDLE: frame_tick moves to UPD with idx=0 and busy=1.
  - UPD: updates ball idx, one ball per cycle. After idx=BALL_NUM-1 returns to IDLE with busy=0.
  - Sweep length is exactly BALL_NUM cycles.
  - frame_tick while busy is ignored.
  - Register outputs update at the end of each UPD cycle.
- INACTIVE update: no change.
- PARKED update:
  - x = paddle_x + paddle_w/2, clamped to [RADIUS, SCREEN_W-1-RADIUS]
  - y = PADDLE_Y-RADIUS-1
  - pending flags discarded
- MOVING update, in order. Arithmetic is signed 12-bit; results are truncated to 10 bits only after clamping.
  1. Apply pending flips: if px, vx=-vx; if py, vy=-vy.
  2. nx = x+vx, ny = y+vy.
  3. Left wall: if nx < RADIUS, nx=RADIUS and vx=|vx|.
  4. Right wall: if nx > SCREEN_W-1-RADIUS, nx=SCREEN_W-1-RADIUS and vx=-|vx|.
  5. Ceiling: if ny < RADIUS, ny=RADIUS and vy=|vy|.
  6. Paddle: applies if all of the following hold:
     - vy > 0
     - y ≤ PADDLE_Y-RADIUS
     - ny ≥ PADDLE_Y-RADIUS
     - paddle_x ≤ nx ≤ paddle_x+paddle_w
     Then ny = PADDLE_Y-RADIUS and vy=-vy.
  7. Floor (checked after the paddle): if ny ≥ SCREEN_H, the ball goes INACTIVE, active[i]=0, xs/ys keep their last value, and lost[i] pulses for one cycle.
- A wall and the ceiling clamp simultaneously in a corner, so both components reflect.
- lost is registered and held high for exactly one cycle.

Test Plan:
- Reset, then serve[0] twice, then one frame_tick with paddle_x=300, paddle_w=40:
  - first serve → active=01, xs[0]=320, ys[0]=431
  - after the tick → xs[0]=322, ys[0]=429; busy high exactly 2 cycles
- MOVING ball at x=9, y=100, vx=-2, vy=-2, tick → x=8 (clamped), vx=+2, y=98.
- Corner: ball at x=631, y=9, vx=+2, vy=-2, tick → x=631, y=8, vx=-2, vy=+2.
- Paddle hit: ball at x=320, y=430, vy=+2, paddle 300..340, tick → y=432, vy=-2. Same stimulus with paddle_x=0 → no reflect.
- Floor loss: ball at y=478, vy=+2, tick → active[0]=0 and lost[0] one cycle high. A following serve[0] re-parks the ball.
- bounce_x[1] pulses in the same cycle ball 1 is updated:
  - the flip is not applied this frame
  - the flag is retained; next tick negates vx
- Assert rst mid-sweep: busy=0 and all outputs return to reset values asynchronously.
